// File: rtl/symbol_stream_feeder_if.sv
// rtl/symbol_stream_feeder_if.sv - host word stream, core symbol stream and control bundle for the feeder
interface symbol_stream_feeder_if #(
    parameter int WORD_LEN = 32,
    parameter int LEN_W    = 16
);
    logic                start;
    logic [LEN_W-1:0]    seq_len;
    logic [WORD_LEN-1:0] in_word;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          symbol;
    logic                sym_valid;
    logic                BC_mode;
    logic                core_done;
    logic                busy;
    logic                done;
    logic                underrun;

    modport master (
        output start, seq_len, in_word, in_valid, core_done,
        input  in_ready, symbol, sym_valid, BC_mode, busy, done, underrun
    );

    modport slave (
        input  start, seq_len, in_word, in_valid, core_done,
        output in_ready, symbol, sym_valid, BC_mode, busy, done, underrun
    );
endinterface

// File: rtl/symbol_stream_feeder.sv
// rtl/symbol_stream_feeder.sv - word FIFO plus MSB-first unpacker pacing 2-bit symbols to the core
module symbol_stream_feeder #(
    parameter int WORD_LEN   = 32,
    parameter int FIFO_AW    = 2,
    parameter int SYM_PERIOD = 2,
    parameter int LEN_W      = 16
) (
    input  logic CLK,
    input  logic RST,
    symbol_stream_feeder_if.slave bus
);
    localparam int SYMS  = WORD_LEN / 2;
    localparam int REM_W = $clog2(SYMS + 1);
    localparam int PH_W  = $clog2(SYM_PERIOD);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SYM_PERIOD - 1);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(SYMS);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;
    state_t state, state_nx;

    logic [WORD_LEN-1:0] mem [DEPTH];
    logic [FIFO_AW:0]    wr_ptr, rd_ptr;
    logic                full, empty, push, in_ready_int;

    logic [WORD_LEN-1:0] word_r;
    logic [REM_W-1:0]    remaining;
    logic [PH_W-1:0]     phase;
    logic [LEN_W-1:0]    count, seq_len_r;
    logic [1:0]          sym_r;
    logic                done_r, underrun_r;
    logic                streaming, load, emit, stall_empty, last_slot, go;

    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // in_ready looks at RST directly so the host sees no acceptance during reset
    assign in_ready_int = RST && !full && (state == IDLE || state == STREAM);
    assign push         = bus.in_valid && in_ready_int;

    assign streaming   = (state == STREAM);
    assign go          = (state == IDLE) && bus.start && (bus.seq_len != '0);
    assign load        = streaming && (remaining == '0) && !empty;
    assign emit        = streaming && (phase == '0) && (remaining != '0);
    assign stall_empty = streaming && (phase == '0) && (remaining == '0) && empty;
    assign last_slot   = streaming && (count == seq_len_r) && (phase == PH_LAST);

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= bus.in_word;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = STREAM;
            STREAM:  if (last_slot) state_nx = DRAIN;
            DRAIN:   if (bus.core_done) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_r     <= '0;
            remaining  <= '0;
            phase      <= '0;
            count      <= '0;
            seq_len_r  <= '0;
            sym_r      <= 2'b00;
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;

            // Reload during a hold cycle lands before the next phase-0 slot, so no bubble
            if (load) begin
                rd_ptr    <= rd_ptr + 1'b1;
                word_r    <= mem[rd_ptr[FIFO_AW-1:0]];
                remaining <= REM_FULL;
            end else if (emit) begin
                sym_r     <= word_r[WORD_LEN-1 -: 2];
                word_r    <= word_r << 2;
                remaining <= remaining - 1'b1;
                count     <= count + 1'b1;
            end

            if (streaming) begin
                if (phase == '0) begin
                    if (emit) phase <= PH_W'(1);
                end else if (phase == PH_LAST) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 1'b1;
                end
            end

            if (go) begin
                seq_len_r <= bus.seq_len;
                count     <= '0;
                phase     <= '0;
            end

            if (stall_empty) underrun_r <= 1'b1;

            done_r <= ((state == IDLE) && bus.start && (bus.seq_len == '0)) ||
                      ((state == DRAIN) && bus.core_done);

            // Leftover symbols and prefetched words belong to the finished sequence
            if (state == FINISH) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                remaining  <= '0;
                underrun_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.symbol    = emit ? word_r[WORD_LEN-1 -: 2] : sym_r;
    assign bus.sym_valid = emit;
    assign bus.BC_mode   = streaming;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.underrun  = underrun_r;
endmodule

// File: tb/tb_symbol_stream_feeder.sv
// tb/tb_symbol_stream_feeder.sv - table, hand-sequence and random checks of symbol_stream_feeder
module tb_symbol_stream_feeder;
    localparam int WL = 32;
    localparam int AW = 2;
    localparam int P  = 2;
    localparam int LW = 16;

    logic CLK = 1'b0;
    logic RST;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    symbol_stream_feeder_if #(.WORD_LEN(WL), .LEN_W(LW)) bus ();

    symbol_stream_feeder #(.WORD_LEN(WL), .FIFO_AW(AW), .SYM_PERIOD(P), .LEN_W(LW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [7:0][31:0] w;
        int n;
        int len;
        int d_on;
        int restart;
        int e_first;
        int e_bclast;
        int e_done;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mkv(input logic [31:0] a, b, c, d, input int n, len, d_on,
                                 restart, ef, eb, ed);
        vec_t v;
        v.w = {128'h0, d, c, b, a};
        v.n = n; v.len = len; v.d_on = d_on; v.restart = restart;
        v.e_first = ef; v.e_bclast = eb; v.e_done = ed;
        return v;
    endfunction

    // Reference: symbol i is the i-th bit pair of the concatenated words, MSB first
    function automatic int sym_of(input logic [7:0][31:0] w, input int i);
        logic [31:0] word;
        word = w[i / 16];
        return int'((word >> (30 - 2 * (i % 16))) & 32'd3);
    endfunction

    task automatic prefill(input logic [7:0][31:0] w, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.in_word  = w[i];
            bus.in_valid = 1'b1;
            chk({tag, " prefill in_ready"}, bus.in_ready, 1);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic stream_check(input logic [7:0][31:0] w, input int len, input int d_on,
                                input int restart, input int ef, input int eb, input int ed,
                                input string tag);
        int t, rel, first, bclast, donec, ndone, prev;
        int got[$];
        bus.seq_len = LW'(len);
        bus.start   = 1'b1;
        t = cyc;
        tick();
        bus.start = 1'b0;
        first = -1; bclast = -1; donec = -1; ndone = 0; prev = -1;
        for (int k = 0; k < len * P + d_on + 40; k++) begin
            rel = cyc - t;
            if (bus.sym_valid) begin
                got.push_back(int'(bus.symbol));
                if (first < 0) first = rel;
                if (prev >= 0) chk({tag, " sym gap"}, rel - prev, P);
                prev = rel;
            end
            if (bus.BC_mode) bclast = rel;
            if (bus.done) begin
                ndone++;
                if (donec < 0) donec = rel;
            end
            if (donec >= 0 && rel > donec) break;
            bus.core_done = (rel >= d_on) && (donec < 0);
            bus.start     = (rel == restart);
            bus.seq_len   = (rel == restart) ? LW'(1) : LW'(len);
            tick();
        end
        bus.start = 1'b0;
        bus.core_done = 1'b0;
        chk({tag, " first sym_valid cycle"}, first, ef);
        chk({tag, " symbol count"}, got.size(), len);
        for (int i = 0; i < len && i < got.size(); i++)
            chk($sformatf("%s symbol %0d", tag, i), got[i], sym_of(w, i));
        chk({tag, " last BC_mode cycle"}, bclast, eb);
        chk({tag, " done cycle"}, donec, ed);
        chk({tag, " done pulses"}, ndone, 1);
        chk({tag, " busy after done"}, bus.busy, 0);
        chk({tag, " underrun after done"}, bus.underrun, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0][31:0] w;
        int t, rel, first, donec, nsv, len, d_on, n;
        int got[$];
        bit dropped, acc_ok;

        vecs[0] = mkv(32'h1B000000, 0, 0, 0, 1, 4, 15, 0, 2, 9, 16);
        vecs[1] = mkv(32'hFFFFFFFF, 32'h00000000, 0, 0, 2, 20, 45, 10, 2, 41, 46);
        vecs[2] = mkv(32'hE4E4E4E4, 0, 0, 0, 1, 1, 3, 0, 2, 3, 5);
        vecs[3] = mkv(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 0, 3, 48, 98, 0, 2, 97, 99);
        vecs[4] = mkv(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hC3C3C3C3, 32'h3C3C3C3C, 4, 16, 40, 0, 2, 33, 41);

        bus.start = 1'b0; bus.seq_len = '0; bus.in_word = '0;
        bus.in_valid = 1'b0; bus.core_done = 1'b0;
        RST = 1'b0;
        repeat (3) tick();
        chk("reset symbol", bus.symbol, 0);
        chk("reset sym_valid", bus.sym_valid, 0);
        chk("reset BC_mode", bus.BC_mode, 0);
        chk("reset done", bus.done, 0);
        chk("reset underrun", bus.underrun, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset in_ready", bus.in_ready, 0);
        RST = 1'b1;
        tick();
        chk("idle in_ready", bus.in_ready, 1);

        // zero-length sequence
        bus.seq_len = '0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("zero len done", bus.done, 1);
        chk("zero len busy", bus.busy, 0);
        chk("zero len BC_mode", bus.BC_mode, 0);
        tick();
        chk("zero len done width", bus.done, 0);
        chk("zero len BC_mode later", bus.BC_mode, 0);

        foreach (vecs[i]) begin
            prefill(vecs[i].w, vecs[i].n, $sformatf("row%0d", i));
            stream_check(vecs[i].w, vecs[i].len, vecs[i].d_on, vecs[i].restart,
                         vecs[i].e_first, vecs[i].e_bclast, vecs[i].e_done,
                         $sformatf("row%0d", i));
        end

        // underrun: empty FIFO at start, one word pushed five cycles later
        bus.seq_len = LW'(2); bus.start = 1'b1;
        t = cyc;
        tick();
        bus.start = 1'b0;
        first = -1; donec = -1; dropped = 1'b0;
        got.delete();
        for (int k = 0; k < 40; k++) begin
            rel = cyc - t;
            if (rel == 1) chk("underrun before stall", bus.underrun, 0);
            if (rel == 2) begin
                chk("underrun set", bus.underrun, 1);
                chk("underrun stall sym_valid", bus.sym_valid, 0);
            end
            if (rel >= 2 && rel <= 12 && !bus.underrun) dropped = 1'b1;
            if (rel == 13) begin
                chk("underrun cleared after finish", bus.underrun, 0);
                break;
            end
            if (bus.sym_valid) begin
                got.push_back(int'(bus.symbol));
                if (first < 0) first = rel;
            end
            if (bus.done && donec < 0) donec = rel;
            bus.in_word  = 32'h40000000;
            bus.in_valid = (rel == 5);
            if (rel == 5) chk("underrun late push in_ready", bus.in_ready, 1);
            bus.core_done = (rel >= 11) && (donec < 0);
            tick();
        end
        bus.in_valid = 1'b0; bus.core_done = 1'b0;
        chk("underrun sticky", dropped, 0);
        chk("underrun first sym", first, 7);
        chk("underrun sym count", got.size(), 2);
        if (got.size() == 2) begin
            chk("underrun sym0", got[0], 1);
            chk("underrun sym1", got[1], 0);
        end
        chk("underrun done cycle", donec, 12);

        // backpressure: four words fill the FIFO, the fifth waits at the host
        for (int i = 0; i < 8; i++) w[i] = (i < 5) ? $urandom : 32'h0;
        prefill(w, 4, "bp");
        bus.in_word = w[4]; bus.in_valid = 1'b1;
        repeat (2) begin
            chk("bp full in_ready", bus.in_ready, 0);
            tick();
        end
        acc_ok = 1'b0;
        fork
            begin
                bit acc;
                for (int k = 0; k < 20; k++) begin
                    acc = bus.in_ready;
                    tick();
                    if (acc) begin
                        acc_ok = 1'b1;
                        break;
                    end
                end
                bus.in_valid = 1'b0;
            end
            stream_check(w, 80, 170, 0, 2, 161, 171, "bp");
        join
        chk("bp fifth word accepted", acc_ok, 1);

        // random prefilled sequences against the reference timing and symbol rules
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) w[i] = (i < n) ? $urandom : 32'h0;
            len  = $urandom_range(1, n * 16);
            d_on = $urandom_range(1, 2 + P * len + 6);
            prefill(w, n, $sformatf("rand%0d", r));
            stream_check(w, len, d_on, 0, 2, 1 + P * len,
                         ((d_on > 2 + P * len) ? d_on : 2 + P * len) + 1,
                         $sformatf("rand%0d", r));
        end

        // reset in the middle of a stream
        prefill(vecs[1].w, 2, "midrst");
        bus.seq_len = LW'(20); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nsv = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.sym_valid) nsv++;
            if (nsv == 3) break;
            tick();
        end
        chk("midrst reached third symbol", nsv, 3);
        #2 RST = 1'b0;
        #1;
        chk("midrst symbol", bus.symbol, 0);
        chk("midrst sym_valid", bus.sym_valid, 0);
        chk("midrst BC_mode", bus.BC_mode, 0);
        chk("midrst done", bus.done, 0);
        chk("midrst underrun", bus.underrun, 0);
        chk("midrst busy", bus.busy, 0);
        chk("midrst in_ready", bus.in_ready, 0);
        repeat (3) begin
            tick();
            chk("midrst no done", bus.done, 0);
        end
        RST = 1'b1;
        tick();
        chk("midrst no done after release", bus.done, 0);
        prefill(vecs[0].w, 1, "after_rst");
        stream_check(vecs[0].w, 4, 15, 0, 2, 9, 16, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
